// File: rtl/cmp_rr_sched_pkg.sv
// Shared types and defaults for the round-robin compare scheduler.
// Imported by the scheduler top and its comparator.
package cmp_rr_sched_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_N_REQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/cmp_rr_sched_mag_cmp.sv
// Unsigned magnitude comparator, purely combinational.
// Exactly one of g/l/e is high for any operand pair.
module mag_cmp
    import cmp_rr_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             g,
    output logic             l,
    output logic             e
);

    assign g = (a > b);
    assign l = (a < b);
    assign e = (a == b);

endmodule

// File: rtl/cmp_rr_sched.sv
// Round-robin scheduler sharing one registered-operand comparator
// among N_REQ requesters; one compare per two cycles at peak.
module cmp_rr_sched
    import cmp_rr_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic                   res_g,
    output logic                   res_l,
    output logic                   res_e
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              done_q, done_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic              res_g_q, res_g_d;
    logic              res_l_q, res_l_d;
    logic              res_e_q, res_e_d;

    logic              cmp_g, cmp_l, cmp_e;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   idx;

    mag_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a (opa_q),
        .b (opb_q),
        .g (cmp_g),
        .l (cmp_l),
        .e (cmp_e)
    );

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_id_d  = cur_id_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        res_g_d   = res_g_q;
        res_l_d   = res_l_q;
        res_e_d   = res_e_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    opa_d    = a_in[win_id*WIDTH +: WIDTH];
                    opb_d    = b_in[win_id*WIDTH +: WIDTH];
                    cur_id_d = win_id;
                    gnt_d    = N_REQ'(1) << win_id;
                    ptr_d    = (win_id == ID_W'(N_REQ - 1))
                             ? '0 : win_id + 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                res_g_d   = cmp_g;
                res_l_d   = cmp_l;
                res_e_d   = cmp_e;
                done_id_d = cur_id_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cur_id_q  <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            res_g_q   <= 1'b0;
            res_l_q   <= 1'b0;
            res_e_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_id_q  <= cur_id_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            res_g_q   <= res_g_d;
            res_l_q   <= res_l_d;
            res_e_q   <= res_e_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == ST_BUSY);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign res_g   = res_g_q;
    assign res_l   = res_l_q;
    assign res_e   = res_e_q;

endmodule

// File: tb/tb_cmp_rr_sched.sv
// Self-checking bench for cmp_rr_sched: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_cmp_rr_sched;

    localparam int N  = 4;
    localparam int W  = 5;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] a_in = '0;
    logic [N*W-1:0] b_in = '0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           done;
    logic [IW-1:0]  done_id;
    logic           res_g, res_l, res_e;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [N-1:0] m_gnt;
    bit           m_busy, m_done, m_g, m_l, m_e;
    int           m_id, m_cur, m_ptr, m_a, m_b;

    cmp_rr_sched #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .res_g   (res_g),
        .res_l   (res_l),
        .res_e   (res_e)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] obs();
        return {gnt, busy, done, done_id, res_g, res_l, res_e};
    endfunction

    function automatic logic [10:0] expv();
        return {m_gnt, m_busy, m_done, IW'(m_id), m_g, m_l, m_e};
    endfunction

    task automatic model_reset();
        m_gnt = '0; m_busy = 0; m_done = 0;
        m_g = 0; m_l = 0; m_e = 0;
        m_id = 0; m_cur = 0; m_ptr = 0; m_a = 0; m_b = 0;
    endtask

    // One compare transaction, stepped at each sampled edge.
    task automatic model_step();
        int w;
        if (m_busy) begin
            m_done = 1;
            m_id   = m_cur;
            m_g    = (m_a > m_b);
            m_l    = (m_a < m_b);
            m_e    = (m_a == m_b);
            m_gnt  = '0;
            m_busy = 0;
        end else begin
            m_done = 0;
            m_gnt  = '0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (w < 0 && req[c]) w = c;
            end
            if (w >= 0) begin
                m_cur  = w;
                m_a    = int'(a_in[w*W +: W]);
                m_b    = int'(b_in[w*W +: W]);
                m_gnt  = 4'(1) << w;
                m_ptr  = (w + 1) % N;
                m_busy = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        a_in[i*W +: W] = W'(a);
        b_in[i*W +: W] = W'(b);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL reset_vals got %b want 0", obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = '0;
        tick();
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL idle_no_req got %b want 0", obs());
        end
    endtask

    task automatic test_single();
        set_op(0, 13, 7);
        req = 4'b0001;
        tick();
        checks++;
        if ({gnt, busy, done} !== 6'b0001_1_0) begin
            errors++;
            $display("FAIL single_gnt got %b want 000110",
                     {gnt, busy, done});
        end
        req = '0;
        tick();
        checks++;
        if ({done, done_id, res_g, res_l, res_e, busy}
            !== 7'b1_00_100_0) begin
            errors++;
            $display("FAIL single_done got %b want 1001000",
                     {done, done_id, res_g, res_l, res_e, busy});
        end
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL single_model got %b want %b", obs(), expv());
        end
        tick();
        checks++;
        if ({done, busy, res_g} !== 3'b001) begin
            errors++;
            $display("FAIL single_hold got %b want 001",
                     {done, busy, res_g});
        end
    endtask

    task automatic test_extremes();
        int         xa[3] = '{21, 0, 31};
        int         xb[3] = '{21, 31, 0};
        logic [2:0] xr[3] = '{3'b001, 3'b010, 3'b100};
        for (int k = 0; k < 3; k++) begin
            set_op(2, xa[k], xb[k]);
            req = 4'b0100;
            tick();
            checks++;
            if (gnt !== 4'b0100) begin
                errors++;
                $display("FAIL ext_gnt%0d got %b want 0100", k, gnt);
            end
            req = '0;
            tick();
            checks++;
            if ({done, done_id, res_g, res_l, res_e}
                !== {1'b1, 2'd2, xr[k]}) begin
                errors++;
                $display("FAIL ext_res%0d got %b want %b", k,
                         {done, done_id, res_g, res_l, res_e},
                         {1'b1, 2'd2, xr[k]});
            end
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int i = 0; i < N; i++)
            set_op(i, $urandom_range(0, 31), $urandom_range(0, 31));
        req = 4'hF;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL fair_model%0d got %b want %b",
                         c, obs(), expv());
            end
            checks++;
            if (c % 2 == 0) begin
                if ({gnt, done} !== {4'(1) << ((c / 2) % N), 1'b0}) begin
                    errors++;
                    $display("FAIL fair_gnt%0d got %b want %0d",
                             c, gnt, (c / 2) % N);
                end
            end else begin
                if ({done, done_id} !== {1'b1, IW'((c / 2) % N)}) begin
                    errors++;
                    $display("FAIL fair_done%0d got %b/%0d want 1/%0d",
                             c, done, done_id, (c / 2) % N);
                end
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_rotation();
        apply_reset();
        set_op(0, 4, 9);
        set_op(1, 17, 2);
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rot_wrap got %b want 0001", gnt);
        end
        tick();
        checks++;
        if ({done, done_id, res_l} !== 4'b1_00_1) begin
            errors++;
            $display("FAIL rot_done got %b want 1001",
                     {done, done_id, res_l});
        end
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL rot_next got %b want 0010", gnt);
        end
        req = '0;
        tick();
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL rot_model got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_op(0, 13, 7);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        set_op(3, 9, 4);
        req = 4'b1000;
        tick();
        checks++;
        if ({gnt, busy, res_g} !== 6'b1000_1_1) begin
            errors++;
            $display("FAIL mid_pre got %b want 100011",
                     {gnt, busy, res_g});
        end
        rst_n = 1'b0;
        model_reset();
        req = 4'b0110;
        set_op(1, 6, 6);
        #1;
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL mid_async got %b want 0", obs());
        end
        tick();
        checks++;
        if (obs() !== 11'd0) begin
            errors++;
            $display("FAIL mid_nodone got %b want 0", obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL mid_first got %b want 0010", gnt);
        end
        req = '0;
        tick();
        checks++;
        if ({done, done_id, res_e} !== 4'b1_01_1) begin
            errors++;
            $display("FAIL mid_done got %b want 1011",
                     {done, done_id, res_e});
        end
    endtask

    task automatic test_back_to_back();
        set_op(1, 3, 9);
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        checks++;
        if ({done, done_id, res_l} !== 4'b1_01_1) begin
            errors++;
            $display("FAIL b2b_first got %b want 1011",
                     {done, done_id, res_l});
        end
        set_op(3, 20, 20);
        req = 4'b1000;
        tick();
        checks++;
        if ({gnt, done, res_g, res_l, res_e} !== 8'b1000_0_010) begin
            errors++;
            $display("FAIL b2b_gnt got %b want 10000010",
                     {gnt, done, res_g, res_l, res_e});
        end
        req = '0;
        tick();
        checks++;
        if ({done, done_id, res_g, res_l, res_e} !== 6'b1_11_001) begin
            errors++;
            $display("FAIL b2b_second got %b want 111001",
                     {done, done_id, res_g, res_l, res_e});
        end
    endtask

    task automatic test_random();
        int waits[N];
        apply_reset();
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL rand_model%0d got %b want %b",
                         c, obs(), expv());
            end
            if (m_gnt != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (i == m_cur) begin
                        checks++;
                        if (waits[i] > N - 1) begin
                            errors++;
                            $display("FAIL rand_starve id%0d got %0d want <=%0d",
                                     i, waits[i], N - 1);
                        end
                        waits[i] = 0;
                    end else if (req[i]) begin
                        waits[i]++;
                    end else begin
                        waits[i] = 0;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!(req[i] && !m_gnt[i])) begin
                    int a, b;
                    a = $urandom_range(0, 31);
                    b = ($urandom_range(0, 3) == 0) ? a
                      : $urandom_range(0, 31);
                    set_op(i, a, b);
                    req[i] = ($urandom_range(0, 2) != 0);
                end
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_fairness();
        test_rotation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_rr_sched.md
Name: cmp_rr_sched

Overview:
- Round-robin scheduler that time-shares one registered-operand WIDTH-bit magnitude comparator (G/L/E) among N_REQ requesters.
- Each requester presents an operand pair and a request. The block grants one requester, compares that pair, and returns G/L/E tagged with the requester id.
- Sits between the lab's per-channel compare clients and a single shared comparator instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 5, operand width in bits.
- ID_W, 2, width of requester id; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester compare request, level.
- a_in  input  N_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- b_in  input  N_REQ*WIDTH  operand B; same packing as a_in.
- gnt  output  N_REQ  one-hot grant pulse, one cycle.
- busy  output  1  high while a compare is in flight (state BUSY).
- done  output  1  result-valid pulse, one cycle.
- done_id  output  ID_W  requester id belonging to the current result.
- res_g  output  1  A > B, unsigned.
- res_l  output  1  A < B, unsigned.
- res_e  output  1  A == B.

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n). All state is cleared immediately on rst_n=0.
- Reset values:
  - State: IDLE.
  - gnt, busy, done: 0.
  - done_id: 0.
  - res_g, res_l, res_e: 0.
  - Round-robin pointer ptr: 0.
  - Operand registers: 0.
- States: IDLE, BUSY.
- IDLE:
  - If req != 0, select the winner: the first asserted req[k], searching k = ptr, ptr+1, … mod N_REQ.
  - At the clock edge: latch a_in/b_in slices of the winner into opa/opb; cur_id <= winner; gnt <= onehot(winner); ptr <= (winner+1) mod N_REQ; state <= BUSY.
  - If req == 0, hold state; gnt stays 0.
- BUSY:
  - gnt is high for exactly this cycle; busy = 1.
  - The comparator evaluates opa/opb combinationally.
  - At the clock edge: res_g/res_l/res_e <= comparator outputs; done_id <= cur_id; done <= 1; gnt <= 0; state <= IDLE.
  - req is ignored in BUSY.
- done is high for one cycle, which coincides with the next IDLE cycle. A new request may be sampled in that same cycle.
- Latency: req sampled in IDLE at cycle t -> gnt at t+1 -> done/results at t+2.
- Peak throughput: one compare per 2 cycles.
- res_* and done_id hold their values until the next done. Exactly one of res_g/res_l/res_e is 1 after the first done.
- Requester contract: operands must be stable from req assertion through the gnt cycle. The requester deasserts req in the gnt cycle if it has no further work. A req still high in IDLE is treated as a new request.
- Simultaneous requests: only the single winner is granted; losers keep req high and win in later rounds in rotating order. No starvation: each requester is served within N_REQ grants.
- ptr wraps from N_REQ-1 to 0.
- Reset mid-operation: the in-flight compare is discarded, no done is issued, and ptr returns to 0.
- Comparison is unsigned over WIDTH bits. No sign handling.

Decomposition:
- Shared package/header holds:
  - State encodings: ST_IDLE = 1'b0, ST_BUSY = 1'b1.
  - Default constants: WIDTH = 5, N_REQ = 4.
- Sub-module mag_cmp (parameter WIDTH): purely combinational, inputs a, b; outputs g, l, e. Instantiated once in cmp_rr_sched.
- Round-robin winner search stays inline in cmp_rr_sched.

Test Plan:
- Single request: req=0001, A0=13, B0=7 -> gnt=0001 at t+1; done=1, done_id=0, res_g=1, res_l=0, res_e=0 at t+2; busy=1 only in cycle t+1.
- Equality and extremes: requester 2 compares 21 vs 21 -> res_e=1. Then 0 vs 31 -> res_l=1. Then 31 vs 0 -> res_g=1.
- Fairness: req=1111 held continuously from reset -> grant order 0, 1, 2, 3, 0; done_id follows the same order; one done every 2 cycles.
- Rotation with gaps: ptr=2, req=0011 -> grant 0 (wrap), ptr becomes 1; next grant goes to requester 1 if still requesting.
- Reset mid-operation: assert rst_n=0 during the BUSY cycle -> gnt, busy, done and res_* drop to 0 immediately; no done follows; first grant after release goes to the lowest-index active requester.
- Back-to-back on the done cycle: requester 3 asserts req in the cycle where done=1 for requester 1 -> gnt=1000 in the next cycle; previous res_* stay valid until the new done.
